// File: rtl/fpg8_timer_pkg.sv
// Shared definitions for the FPG8 multi-channel timer: mode encodings and
// the per-channel command produced by the bank's priority decode.
package fpg8_timer_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOAD = 2'd1,
        MODE = 2'd2,
        ACK  = 2'd3
    } timer_cmd_e;

    // Only one command per cycle reaches a channel: load beats mode beats ack.
    function automatic timer_cmd_e decode_cmd(input logic load, input logic mode, input logic ack);
        if (load) begin
            return LOAD;
        end else if (mode) begin
            return MODE;
        end else if (ack) begin
            return ACK;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: reloadable counter with one-shot/periodic mode,
// sticky timeout flag and a registered one-cycle expiry pulse.
module timer_channel
    import fpg8_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             timeout,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_cmd_e       cmd_e;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;
    logic             expire_q, expire_d;
    logic             expiring;

    assign cmd_e    = timer_cmd_e'(cmd);
    assign expiring = tick && running_q && (count_q == ONE);

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        running_d = running_q;
        timeout_d = timeout_q;
        expire_d  = 1'b0;

        if (expiring) begin
            timeout_d = 1'b1;
            expire_d  = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
                count_d = reload_q;
            end else begin
                count_d   = '0;
                running_d = 1'b0;
            end
        end else if (tick && running_q && (count_q > ONE)) begin
            count_d = count_q - ONE;
        end

        // A load overrides a same-cycle expiry; an ack loses to one.
        case (cmd_e)
            LOAD: begin
                count_d   = data;
                reload_d  = data;
                running_d = |data;
                timeout_d = 1'b0;
                expire_d  = 1'b0;
            end
            MODE:    mode_d    = data[0];
            ACK:     timeout_d = expiring;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= MODE_ONESHOT;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            expire_q  <= expire_d;
        end
    end

    assign count   = count_q;
    assign timeout = timeout_q;
    assign expire  = expire_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel countdown timer on the shared FPG8 bus: shared prescaler,
// per-channel command decode, combinational count readback and irq.
module timer_bank
    import fpg8_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    inout  wire  [WIDTH-1:0]                             DATA,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] sel,
    input  logic                                         timer_in,
    input  logic                                         timer_out,
    input  logic                                         mode_in,
    input  logic                                         ack,
    output logic [CHANNELS-1:0]                          timeout,
    output logic [CHANNELS-1:0]                          expire,
    output logic                                         irq,
    output logic [WIDTH-1:0]                             REG_OUT_TIMER
);

    localparam int            PW         = $clog2(PRESCALE > 1 ? PRESCALE : 2);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic             sel_valid;
    timer_cmd_e       bank_cmd;
    timer_cmd_e       ch_cmd [CHANNELS];
    logic [WIDTH-1:0] ch_count [CHANNELS];
    logic [WIDTH-1:0] rd_count;

    // Free-running; a load never restarts it, so first-tick latency varies.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign sel_valid = (int'(sel) < CHANNELS);
    assign bank_cmd  = decode_cmd(timer_in, mode_in, ack);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign ch_cmd[gi] = (sel_valid && (int'(sel) == gi)) ? bank_cmd : NONE;

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .cmd     (ch_cmd[gi]),
            .data    (DATA),
            .count   (ch_count[gi]),
            .timeout (timeout[gi]),
            .expire  (expire[gi])
        );
    end

    always_comb begin
        rd_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_valid && (int'(sel) == i)) begin
                rd_count = ch_count[i];
            end
        end
    end

    assign REG_OUT_TIMER = rd_count;
    assign DATA          = timer_out ? rd_count : {WIDTH{1'bz}};
    assign irq           = |timeout;

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel countdown timer for the FPG8 datapath; the next generation of the single-channel `timer`. It sits on the shared 16-bit bus like the other registers. The control unit loads, reads, configures and acknowledges one channel per cycle through a select field. Each channel counts down on a shared prescaled tick, runs in one-shot or periodic mode, and raises a sticky timeout flag, which is ORed into `irq` for the control unit.

## Interface
Parameters:
- `WIDTH`, 16: counter and bus width.
- `CHANNELS`, 4: number of independent channels (≥1).
- `PRESCALE`, 1: clk cycles per count tick (≥1).

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: reset is asynchronous and active-high.
- `DATA`, inout, WIDTH: shared bus; driven only while `timer_out`=1, else high-Z.
- `sel`, in, max(1,$clog2(CHANNELS)): channel addressed by `timer_in`/`timer_out`/`mode_in`/`ack`; values ≥CHANNELS are ignored, and reads of them return 0.
- `timer_in`, in, 1: load `DATA` into count and reload of `sel`.
- `timer_out`, in, 1: drive current count of `sel` onto `DATA`.
- `mode_in`, in, 1: latch `DATA[0]` as mode of `sel` (0 one-shot, 1 periodic).
- `ack`, in, 1: clear timeout flag of `sel`.
- `timeout`, out, CHANNELS: sticky per-channel timeout flags.
- `expire`, out, CHANNELS: registered one-cycle pulse on each expiry.
- `irq`, out, 1: OR of `timeout`.
- `REG_OUT_TIMER`, out, WIDTH: debug; count of `sel`.

## Operation
- Per-channel state: `count`, `reload`, `mode`, `running`, `timeout`.
- Prescaler: free-running 0..PRESCALE-1; `tick`=1 in the cycle it equals PRESCALE-1. PRESCALE=1 gives a tick every cycle.
- Load (`timer_in`), nonzero value: count=reload=DATA, running=1, timeout cleared.
- Load of zero: count=reload=0, running=0, timeout cleared.
- On a tick, a running channel with count>1 decrements.
- On a tick with count==1, the channel expires:
  - timeout=1 and expire pulses.
  - One-shot: count=0, running=0.
  - Periodic: count=reload, running stays 1.
- Stopped channels hold their value.
- `mode_in` changes only the mode. It applies from the next expiry and does not restart the count.
- Command priority when more than one is asserted in a cycle: `timer_in` > `mode_in` > `ack`. Lower-priority commands that cycle are dropped. `timer_out` is independent.
- Simultaneous events on the same channel:
  - load + expiry: the load wins, timeout cleared, no expire pulse.
  - ack + expiry: set wins, timeout=1.
- Events on other channels proceed in parallel.
- Arithmetic is unsigned WIDTH-bit. The counter never wraps below 0.

## Timing
- Reset values:
  - All counts, reloads, modes, running, timeout and expire are 0.
  - Prescaler is 0, `irq`=0, `DATA` high-Z, `REG_OUT_TIMER`=0.
- Reset mid-count aborts immediately (asynchronous), with no expire pulse.
- `DATA` and `REG_OUT_TIMER` reads are combinational, same cycle.
- Expiry latency with PRESCALE=1: a value V loaded at edge 0 reaches count 0 and sets timeout at edge V.
- With PRESCALE=P, expiry lands on the V-th tick after the load edge. Latency is V·P cycles, up to P-1 cycles less depending on prescaler phase, because the prescaler is not restarted by a load.
- Periodic period is exactly V·P cycles; `expire` is high for 1 cycle per period.
- `irq` is combinational from the `timeout` flops.

## Structure
- Package `fpg8_timer_pkg`:
  - `MODE_ONESHOT`=1'b0 and `MODE_PERIODIC`=1'b1.
  - A `timer_cmd_e` enum (NONE, LOAD, MODE, ACK) for the priority decode.
- Sub-module `timer_channel`, instantiated CHANNELS times from a generate loop. Inputs: tick, decoded per-channel command, `DATA`. It holds count/reload/mode/running/timeout/expire.
- `timer_bank` owns the prescaler, command decode, read mux, tristate and `irq`.

## Test plan
- Reset mid-run: load 5 on ch0, assert reset after 2 cycles → count 0, timeout 0, DATA Z, no expire; behaviour identical to fresh power-up.
- One-shot, PRESCALE=1: load 3 on ch1 at edge 0 → counts 2,1,0 at edges 1–3; timeout[1]=1 and expire[1] pulse at edge 3; count stays 0; irq=1 until ack, then 0.
- Periodic: mode_in DATA=1 on ch2, then load 4 → expire[2] pulses at edges 4, 8, 12; count reloads to 4 each time; timeout stays 1 until ack.
- Same-cycle collisions:
  - ack on ch0 in its expiry cycle → timeout[0]=1.
  - Load 7 on ch0 in its expiry cycle → count 7, timeout 0, no pulse.
  - timer_in+ack together → ack ignored.
- PRESCALE=4, CHANNELS=3: load 2 on ch0 and 5 on ch2 → ch0 expires on its 2nd tick, ch2 on its 5th. Readback via timer_out matches REG_OUT_TIMER. sel=3 read returns 0 and writes are ignored.
